// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter.
// Edge- or center-aligned counting, per-channel duty and polarity,
// shadow/active double buffering applied at the period boundary,
// complementary registered outputs.
// Optional feature macro: PWM_DEADTIME_EN adds per-channel dead-time
// insertion (both outputs low for dead_time cycles after each level change).
module pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int DEAD_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      center,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic [DEAD_WIDTH-1:0]     dead_time,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS-1:0]       pwm_out_n,
    output logic [WIDTH-1:0]          count_out,
    output logic                      period_tick,
    output logic                      load_pending
);

    typedef struct packed {
        logic [WIDTH-1:0]          period;
        logic [CHANNELS*WIDTH-1:0] duty;
        logic [CHANNELS-1:0]       pol;
        logic                      center;
    } cfg_t;

    cfg_t                in_cfg;
    cfg_t                shadow_q, shadow_d;
    cfg_t                active_q, active_d;
    logic                pending_q, pending_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                down_q, down_d;
    logic                boundary;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] out_n_q, out_n_d;

    assign in_cfg = '{period: period, duty: duty, pol: polarity, center: center};

    // Shared counter: edge mode wraps P->0, center mode ramps up to P and back
    // down to 1 before returning to 0. Disabled means held at 0 counting up.
    always_comb begin
        count_d = count_q;
        down_d  = down_q;
        if (!enable) begin
            count_d = '0;
            down_d  = 1'b0;
        end else if (!active_q.center) begin
            down_d = 1'b0;
            if (count_q >= active_q.period) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (!down_q) begin
            if (count_q >= active_q.period) begin
                // P of 0 or 1 has no down ramp: go straight back to 0
                if (count_q <= WIDTH'(1)) begin
                    count_d = '0;
                    down_d  = 1'b0;
                end else begin
                    count_d = count_q - 1'b1;
                    down_d  = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end else begin
            if (count_q <= WIDTH'(1)) begin
                count_d = '0;
                down_d  = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // A boundary is any edge into count 0; while disabled every edge is one,
    // so a load is applied to the active set immediately.
    assign boundary = (count_d == '0);

    // Shadow/active update: load on a boundary bypasses the shadow stage.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary) begin
            if (load) begin
                active_d  = in_cfg;
                shadow_d  = in_cfg;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = in_cfg;
            pending_d = 1'b1;
        end
    end

    // Per-channel compare against the active duty, then polarity inversion.
    always_comb begin
        level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level[i] = (count_q < active_q.duty[i*WIDTH +: WIDTH]) ^ active_q.pol[i];
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [CHANNELS-1:0][DEAD_WIDTH-1:0] dead_q, dead_d;
    logic [CHANNELS-1:0]                 lvl_prev_q, lvl_prev_d;

    // Dead-band down-counter reloads on every level change; both sides stay
    // low until it has run out, so the asserting edge is delayed.
    always_comb begin
        dead_d     = dead_q;
        lvl_prev_d = enable ? level : '0;
        out_d      = '0;
        out_n_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!enable) begin
                dead_d[i] = '0;
            end else if (level[i] != lvl_prev_q[i]) begin
                dead_d[i] = dead_time;
            end else if (dead_q[i] != '0) begin
                dead_d[i] = dead_q[i] - 1'b1;
            end
            out_d[i]   = enable && (dead_d[i] == '0) && level[i];
            out_n_d[i] = enable && (dead_d[i] == '0) && !level[i];
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;

    // Plain complementary outputs, forced low while disabled.
    always_comb begin
        out_d   = enable ? level  : '0;
        out_n_d = enable ? ~level : '0;
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            down_q    <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            out_q     <= '0;
            out_n_q   <= '0;
`ifdef PWM_DEADTIME_EN
            dead_q     <= '0;
            lvl_prev_q <= '0;
`endif
        end else begin
            count_q   <= count_d;
            down_q    <= down_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            out_n_q   <= out_n_d;
`ifdef PWM_DEADTIME_EN
            dead_q     <= dead_d;
            lvl_prev_q <= lvl_prev_d;
`endif
        end
    end

    assign pwm_out      = out_q;
    assign pwm_out_n    = out_n_q;
    assign count_out    = count_q;
    assign load_pending = pending_q;
    assign period_tick  = enable && (count_q == '0);

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes expected per-cycle
// responses into a queue, a negedge monitor pops and compares them.
module tb_pwm_multi;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, enable, center, load;
    logic [W-1:0]  period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0] polarity;
    logic [DW-1:0] dead_time;
    logic [CH-1:0] pwm_out, pwm_out_n;
    logic [W-1:0]  count_out;
    logic          period_tick, load_pending;

    pwm_multi #(.CHANNELS(CH), .WIDTH(W), .DEAD_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .center(center),
        .period(period), .duty(duty), .polarity(polarity),
        .dead_time(dead_time), .load(load),
        .pwm_out(pwm_out), .pwm_out_n(pwm_out_n), .count_out(count_out),
        .period_tick(period_tick), .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mask bits: 0 pwm_out, 1 pwm_out_n, 2 count, 3 tick, 4 pending
    typedef struct {
        int         cy;
        logic [3:0] o;
        logic [3:0] n;
        logic [7:0] c;
        logic       t;
        logic       p;
        logic [4:0] m;
        string      name;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic expect_at(input int cy, input logic [3:0] o, input logic [3:0] n,
                             input logic [7:0] c, input logic t, input logic p,
                             input logic [4:0] m, input string name);
        exp_t e;
        e.cy = cy; e.o = o; e.n = n; e.c = c; e.t = t; e.p = p; e.m = m; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic ok;
        while (sb.size() > 0 && sb[0].cy <= cyc) begin
            e  = sb.pop_front();
            ok = (e.cy == cyc);
            if (e.m[0] && pwm_out      !== e.o) ok = 1'b0;
            if (e.m[1] && pwm_out_n    !== e.n) ok = 1'b0;
            if (e.m[2] && count_out    !== e.c) ok = 1'b0;
            if (e.m[3] && period_tick  !== e.t) ok = 1'b0;
            if (e.m[4] && load_pending !== e.p) ok = 1'b0;
            n_total++;
            if (ok) n_pass++;
            else $display("FAIL %s cyc=%0d(exp %0d): got out=%b n=%b cnt=%0d tick=%b pend=%b, want out=%b n=%b cnt=%0d tick=%b pend=%b mask=%b",
                          e.name, cyc, e.cy, pwm_out, pwm_out_n, count_out, period_tick,
                          load_pending, e.o, e.n, e.c, e.t, e.p, e.m);
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Disable for one cycle while loading, then enable: count is 0 on return.
    task automatic prelude(input logic ctr, input logic [7:0] p, input logic [31:0] d,
                           input logic [3:0] pol);
        rst = 1'b0; enable = 1'b0; load = 1'b1;
        center = ctr; period = p; duty = d; polarity = pol;
        step(1);
        load = 1'b0; enable = 1'b1;
    endtask

    initial begin
        int t0;
        int x;
        rst = 1'b1; enable = 1'b0; center = 1'b0; load = 1'b0;
        period = '0; duty = '0; polarity = '0; dead_time = '0;

        // reset state
        step(2);
        expect_at(cyc + 1, 4'h0, 4'h0, 8'd0, 1'b0, 1'b0, 5'h1f, "reset");
        step(1);

        // edge-aligned, P=9, D={5,10,0,3}, ch3 inverted
        prelude(1'b0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b1000);
        t0 = cyc;
        for (int j = 0; j < 25; j++) begin
            int k;
            logic [3:0] o;
            k = (j + 9) % 10;
            o = '0;
            if (j > 0) begin
                o[0] = (k < 3);
                o[1] = 1'b0;
                o[2] = 1'b1;
                o[3] = !(k < 5);
            end
            expect_at(t0 + j, o, (j == 0) ? 4'h0 : ~o, 8'(j % 10), (j % 10) == 0,
                      1'b0, 5'h1f, "edge");
        end
        step(25);

        // center-aligned, P=8, D0=4: 16-cycle period
        prelude(1'b1, 8'd8, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000);
        t0 = cyc;
        for (int j = 0; j < 34; j++) begin
            int m, mp, c, cp;
            logic [3:0] o;
            m  = j % 16;
            c  = (m <= 8) ? m : 16 - m;
            mp = (j + 15) % 16;
            cp = (mp <= 8) ? mp : 16 - mp;
            o  = '0;
            if (j > 0) o[0] = (cp < 4);
            expect_at(t0 + j, o, (j == 0) ? 4'h0 : ~o, 8'(c), m == 0,
                      1'b0, 5'h1f, "center");
        end
        step(34);

        // mid-period load D0 3->7 at count 5; unloaded input change ignored
        prelude(1'b0, 8'd9, {24'h0, 8'd3}, 4'b0000);
        t0 = cyc;
        for (int j = 0; j < 26; j++) begin
            int k, d;
            logic [3:0] o;
            k = (j + 9) % 10;
            d = ((j - 1) < 10) ? 3 : 7;
            o = '0;
            if (j > 0) o[0] = (k < d);
            expect_at(t0 + j, o, (j == 0) ? 4'h0 : ~o, 8'(j % 10), (j % 10) == 0,
                      (j >= 6 && j <= 9), 5'h1f, "midload");
        end
        step(5);
        load = 1'b1; duty[7:0] = 8'd7;
        step(1);
        load = 1'b0; duty[7:0] = 8'd1;
        step(20);

        // load on boundary (bypass), then two loads before the next boundary
        prelude(1'b0, 8'd9, {24'h0, 8'd3}, 4'b0000);
        t0 = cyc;
        for (int j = 0; j < 30; j++) begin
            int k, d;
            logic [3:0] o;
            k = (j + 9) % 10;
            d = ((j - 1) < 10) ? 3 : (((j - 1) < 20) ? 6 : 8);
            o = '0;
            if (j > 0) o[0] = (k < d);
            expect_at(t0 + j, o, (j == 0) ? 4'h0 : ~o, 8'(j % 10), (j % 10) == 0,
                      (j >= 13 && j <= 19), 5'h1f, "bndload");
        end
        step(9);
        load = 1'b1; duty[7:0] = 8'd6;
        step(1);
        load = 1'b0;
        step(2);
        load = 1'b1; duty[7:0] = 8'd2;
        step(1);
        load = 1'b0;
        step(1);
        load = 1'b1; duty[7:0] = 8'd8;
        step(1);
        load = 1'b0;
        step(15);

        // reset mid-period with a pending load and enable high
        step(3);
        x = cyc;
        load = 1'b1; duty[7:0] = 8'd5;
        expect_at(x + 1, 4'h0, 4'h0, 8'd4, 1'b0, 1'b1, 5'h14, "pend_pre_rst");
        expect_at(x + 2, 4'h0, 4'h0, 8'd0, 1'b0, 1'b0, 5'h17, "rst_mid");
        expect_at(x + 3, 4'h0, 4'hf, 8'd0, 1'b1, 1'b0, 5'h1f, "after_rst");
        step(1);
        load = 1'b0; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

`ifdef PWM_DEADTIME_EN
        // dead time 2, P=9, D0=4: two blank cycles at every transition
        dead_time = 4'd2;
        prelude(1'b0, 8'd9, {24'h0, 8'd4}, 4'b0000);
        t0 = cyc;
        for (int j = 0; j < 25; j++) begin
            int k;
            logic lv, blank;
            logic [3:0] o, n;
            k     = (j + 9) % 10;
            lv    = (k < 4);
            blank = (k == 0 || k == 1 || k == 4 || k == 5);
            o = '0;
            n = '0;
            if (j > 0) begin
                o[0] = !blank && lv;
                n[0] = !blank && !lv;
                n[3:1] = 3'b111;
            end
            expect_at(t0 + j, o, n, 8'(j % 10), (j % 10) == 0, 1'b0, 5'h1f, "deadtime");
        end
        step(25);
`endif

        step(2);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
